// File: rtl/pwm_ramp_sequencer.sv
// pwm_ramp_sequencer: PWM configuration register bank with a duty-cycle ramp engine
//   clk, rst                          : clock, synchronous active-high reset
//   host_wr_valid/addr/data           : single-cycle byte write from the SPI host
//   en_reg_out_*, en_reg_pwm_*        : output / PWM-mode enables
//   pwm_duty_cycle                    : current duty, shared by host writes and the ramp
//   ramp_busy, ramp_done              : ramp active / non-bounce target-reached pulse
//   SEQ_READBACK_EN (macro)           : adds host_rd_addr / registered host_rd_data
module pwm_ramp_sequencer #(
   parameter int TICK_DIV = 1000,
   parameter int TICK_W   = 10
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       host_wr_valid,
   input  logic [2:0] host_wr_addr,
   input  logic [7:0] host_wr_data,
`ifdef SEQ_READBACK_EN
   input  logic [2:0] host_rd_addr,
   output logic [7:0] host_rd_data,
`endif
   output logic [7:0] en_reg_out_7_0,
   output logic [7:0] en_reg_out_15_8,
   output logic [7:0] en_reg_pwm_7_0,
   output logic [7:0] en_reg_pwm_15_8,
   output logic [7:0] pwm_duty_cycle,
   output logic       ramp_busy,
   output logic       ramp_done
);
   typedef enum logic {IDLE, RAMP} state_t;
   state_t state, state_nxt;
   logic [7:0] target, step, origin, eff, diff, duty_step;
   logic [TICK_W-1:0] tick;
   logic bounce, done_nxt;
   logic wr_duty, wr_ctrl, start, stop, tick_end, step_evt, reached, at_target;
   assign wr_duty   = host_wr_valid && host_wr_addr == 3'd4;
   assign wr_ctrl   = host_wr_valid && host_wr_addr == 3'd7;
   assign start     = wr_ctrl && host_wr_data[0];
   assign stop      = wr_ctrl && !host_wr_data[0];
   assign tick_end  = tick == TICK_W'(TICK_DIV - 1);
   // a host duty or ctrl write in the same cycle takes precedence over the step
   assign step_evt  = state == RAMP && tick_end && !wr_duty && !wr_ctrl;
   assign eff       = step == 8'd0 ? 8'd1 : step;
   assign diff      = pwm_duty_cycle > target ? pwm_duty_cycle - target : target - pwm_duty_cycle;
   assign duty_step = diff <= eff ? target
                    : pwm_duty_cycle < target ? pwm_duty_cycle + eff : pwm_duty_cycle - eff;
   assign reached   = step_evt && duty_step == target;
   assign at_target = pwm_duty_cycle == target;
   assign ramp_busy = state == RAMP;
   always_comb begin
      state_nxt = state;
      done_nxt  = 1'b0;
      if (wr_duty) state_nxt = IDLE;
      else if (start) begin
         state_nxt = at_target ? IDLE : RAMP;
         done_nxt  = at_target;
      end
      else if (stop) state_nxt = IDLE;
      else if (reached && !bounce) begin
         state_nxt = IDLE;
         done_nxt  = 1'b1;
      end
   end
   always_ff @(posedge clk)
      if (rst) state <= IDLE;
      else state <= state_nxt;
   always_ff @(posedge clk)
      if (rst) begin
         {en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8} <= '0;
         {pwm_duty_cycle, target, step, origin} <= '0;
         bounce    <= 1'b0;
         ramp_done <= 1'b0;
         tick      <= '0;
      end else begin
         ramp_done <= done_nxt;
         tick      <= (start || state_nxt != RAMP || tick_end) ? '0 : tick + TICK_W'(1);
         if (host_wr_valid && host_wr_addr == 3'd0) en_reg_out_7_0  <= host_wr_data;
         if (host_wr_valid && host_wr_addr == 3'd1) en_reg_out_15_8 <= host_wr_data;
         if (host_wr_valid && host_wr_addr == 3'd2) en_reg_pwm_7_0  <= host_wr_data;
         if (host_wr_valid && host_wr_addr == 3'd3) en_reg_pwm_15_8 <= host_wr_data;
         if (host_wr_valid && host_wr_addr == 3'd6) step <= host_wr_data;
         pwm_duty_cycle <= wr_duty ? host_wr_data : step_evt ? duty_step : pwm_duty_cycle;
         // bounce reverses direction by swapping the endpoints
         target <= (host_wr_valid && host_wr_addr == 3'd5) ? host_wr_data
                 : (reached && bounce) ? origin : target;
         origin <= start ? pwm_duty_cycle : (reached && bounce) ? target : origin;
         bounce <= start ? host_wr_data[1] : bounce;
      end
`ifdef SEQ_READBACK_EN
   always_ff @(posedge clk)
      if (rst) host_rd_data <= '0;
      else
         case (host_rd_addr)
            3'd0:    host_rd_data <= en_reg_out_7_0;
            3'd1:    host_rd_data <= en_reg_out_15_8;
            3'd2:    host_rd_data <= en_reg_pwm_7_0;
            3'd3:    host_rd_data <= en_reg_pwm_15_8;
            3'd4:    host_rd_data <= pwm_duty_cycle;
            3'd5:    host_rd_data <= target;
            3'd6:    host_rd_data <= step;
            default: host_rd_data <= {5'b0, ramp_busy, bounce, ramp_busy};
         endcase
`endif
endmodule

// File: doc/pwm_ramp_sequencer.md
Name: pwm_ramp_sequencer

Overview:
Register bank and sequencer that configures the PWM peripheral. It owns the five PWM configuration registers: output enables [15:0], PWM enables [15:0] and duty cycle. It accepts single-cycle byte writes from the SPI host interface and adds a ramp engine that steps pwm_duty_cycle toward a programmed target at a fixed tick rate. Host writes and the ramp engine share the duty register; the host always wins.

Parameters:
TICK_DIV, 1000, clock cycles per ramp step (>=2)
TICK_W, 10, width of tick counter (must hold TICK_DIV-1)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
host_wr_valid  in  1  one-cycle write strobe from SPI peripheral
host_wr_addr  in  3  register address
host_wr_data  in  8  write data
en_reg_out_7_0  out  8  output enable, bits 7:0
en_reg_out_15_8  out  8  output enable, bits 15:8
en_reg_pwm_7_0  out  8  PWM mode enable, bits 7:0
en_reg_pwm_15_8  out  8  PWM mode enable, bits 15:8
pwm_duty_cycle  out  8  current duty cycle
ramp_busy  out  1  high while state is RAMP
ramp_done  out  1  one-cycle pulse when the ramp reaches target (non-bounce)

Behaviour:
- One clock domain: clk. Reset: synchronous, active-high (rst).
- Reset: all outputs 0, target=0, step=0, origin=0, tick=0, state IDLE.
- Address map (write-only):
  - 0 en_reg_out_7_0; 1 en_reg_out_15_8; 2 en_reg_pwm_7_0; 3 en_reg_pwm_15_8
  - 4 pwm_duty_cycle; 5 ramp_target; 6 ramp_step
  - 7 ramp_ctrl: bit0 run, bit1 bounce; bits 7:2 ignored
- Writes take effect on the edge where host_wr_valid is sampled, so they are visible the next cycle. No backpressure; every write is accepted.
- FSM states IDLE, RAMP.
- IDLE -> RAMP:
  - Trigger: write addr 7 with bit0=1.
  - Latches bounce, sets origin = current duty, clears tick.
  - If duty == target at start, go straight to IDLE with a ramp_done pulse.
- RAMP -> RAMP restart: write addr 7 with bit0=1; re-latches bounce and origin, clears tick.
- RAMP -> IDLE on any of:
  - write addr 7 with bit0=0 (no done pulse);
  - host write addr 4 (duty takes the host value, ramp aborted, no done pulse);
  - target reached with bounce=0 (ramp_done pulses the same cycle ramp_busy falls).
- Tick counter:
  - Runs only in RAMP, counting 0..TICK_DIV-1.
  - On the cycle it equals TICK_DIV-1, it wraps to 0 and applies one step.
  - The first duty change is visible exactly TICK_DIV cycles after the start write is sampled.
- Step arithmetic (unsigned 8-bit, no wrap):
  - eff_step = (step==0) ? 1 : step.
  - If |target-duty| <= eff_step, duty := target; else duty moves toward target by eff_step.
- Bounce: on reaching target with bounce=1, swap target and origin and continue in RAMP with tick cleared. No done pulse.
- Writes to addr 5 or 6 during RAMP apply from the next step; no restart.
- Same-cycle host write to addr 4 and step event: host value wins and ramp aborts.
- Writes to addrs 0-3 never affect the FSM.
- rst asserted mid-ramp: everything returns to reset values on that edge.

Optional Feature:
SEQ_READBACK_EN
- Defined:
  - Adds ports host_rd_addr (in, 3) and host_rd_data (out, 8).
  - host_rd_data is registered: 1-cycle latency, reset 0.
  - Returns the register at host_rd_addr.
  - Addr 7 returns {5'b0, ramp_busy, bounce, ramp_busy}.
- Undefined: ports absent, no read logic.

Test Plan:
- Reset: assert rst 2 cycles with host_wr_valid=1 -> all outputs 0, ramp_busy=0; writes during reset ignored.
- Bank write: write addr0=0xA5, addr3=0x3C, addr4=0x80 -> next cycle en_reg_out_7_0=0xA5, en_reg_pwm_15_8=0x3C, pwm_duty_cycle=0x80; others 0.
- Ramp up with saturation (TICK_DIV=4): duty=0x10, target=0x20, step=0x06, ctrl=0x01 -> duty 0x16, 0x1C, 0x20 at 4, 8, 12 cycles after start; ramp_done pulses once at 12; ramp_busy low thereafter.
- Bounce (TICK_DIV=4): duty=0x00, target=0x02, step=0x01, ctrl=0x03 -> duty 1,2,1,0,1,... every 4 cycles; no ramp_done; write ctrl=0x00 -> holds value, ramp_busy=0 next cycle.
- Host override: mid-ramp, write addr4=0x55 on the same cycle as a step event -> duty=0x55, ramp_busy=0, no ramp_done.
- Step 0 and reset mid-ramp: step=0, target=duty+3 -> +1 per tick; assert rst after first step -> all zero next cycle, no further steps.
